// File: rtl/approx_pkg.sv
// Shared state encoding and default widths for the approximate dot-product accumulator.
package approx_pkg;

    localparam int PW = 16;
    localparam int AW = 24;
    localparam int LW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/approx_dot_accum_if.sv
// Handshake bundle between the product source, the accumulator and the result sink.
interface approx_dot_accum_if #(
    parameter int PW = approx_pkg::PW,
    parameter int AW = approx_pkg::AW,
    parameter int LW = approx_pkg::LW
);

    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic [PW-1:0] in_p;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_sat;
    logic          busy;

    modport slave (
        input  start, len, in_valid, in_p, out_ready,
        output in_ready, out_valid, out_acc, out_sat, busy
    );

    modport master (
        output start, len, in_valid, in_p, out_ready,
        input  in_ready, out_valid, out_acc, out_sat, busy
    );

endinterface

// File: rtl/sat_add.sv
// Signed accumulate step: AW-bit acc plus sign-extended PW-bit product, AW+1 bits wide.
// APPROX_DOT_ACCUM_SAT_EN selects clamping on overflow; otherwise the sum wraps.
module sat_add #(
    parameter int PW = 16,
    parameter int AW = 24
) (
    input  logic [AW-1:0] a,
    input  logic [PW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [AW:0] wide;

    assign wide = {a[AW-1], a} + {{(AW+1-PW){b[PW-1]}}, b};
    assign ovf  = wide[AW] ^ wide[AW-1];

`ifdef APPROX_DOT_ACCUM_SAT_EN
    always_comb begin
        sum = wide[AW-1:0];
        if (ovf) begin
            sum = wide[AW] ? {1'b1, {(AW-1){1'b0}}}
                           : {1'b0, {(AW-1){1'b1}}};
        end
    end
`else
    assign sum = wide[AW-1:0];
`endif

endmodule

// File: rtl/approx_dot_accum.sv
// Accumulates len signed products into a signed result with valid/ready on both sides.
// APPROX_DOT_ACCUM_SAT_EN enables saturating adds and the sticky out_sat flag.
module approx_dot_accum
    import approx_pkg::*;
#(
    parameter int PW = approx_pkg::PW,
    parameter int AW = approx_pkg::AW,
    parameter int LW = approx_pkg::LW
) (
    input logic              clk,
    input logic              rst_n,
    approx_dot_accum_if.slave bus
);

    state_t        state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] count;
    logic [AW-1:0] acc;
    logic          sat;
    logic          in_ready;
    logic          out_valid;
    logic          busy;

    logic [AW-1:0] sum;
    logic          ovf;
    logic          sat_hit;
    logic          last;

    sat_add #(
        .PW(PW),
        .AW(AW)
    ) u_add (
        .a  (acc),
        .b  (bus.in_p),
        .sum(sum),
        .ovf(ovf)
    );

`ifdef APPROX_DOT_ACCUM_SAT_EN
    assign sat_hit = ovf;
`else
    // Wrapping build: overflow never sets the sticky flag.
    assign sat_hit = 1'b0;
    wire unused_ovf = ovf;
`endif

    assign last = (count + LW'(1)) == len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q <= bus.len;
                        acc   <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                        busy  <= 1'b1;
                        if (bus.len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc   <= sum;
                        count <= count + LW'(1);
                        sat   <= sat | sat_hit;
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_acc   = acc;
    assign bus.out_sat   = sat;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_approx_dot_accum.sv
// Randomized bench for approx_dot_accum against a transaction-level arithmetic model.
// Honours APPROX_DOT_ACCUM_SAT_EN the same way as the design.
module tb_approx_dot_accum;

    localparam int PW  = 16;
    localparam int AW  = 24;
    localparam int LW  = 8;
    localparam int SAW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    approx_dot_accum_if #(.PW(PW), .AW(AW),  .LW(LW)) bus ();
    approx_dot_accum_if #(.PW(PW), .AW(SAW), .LW(LW)) sbus ();

    approx_dot_accum #(.PW(PW), .AW(AW), .LW(LW)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    approx_dot_accum #(.PW(PW), .AW(SAW), .LW(LW)) u_small (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sbus)
    );

    int     checks = 0;
    int     errors = 0;
    int     phase  = 0;
    longint exp_acc = 0;
    bit     exp_sat = 1'b0;
    int     vq[$];
    int     sq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact integer sum, then clamp or wrap to aw bits.
    task automatic model_add(input int aw, input longint p,
                             inout longint acc, inout bit sat);
        longint hi;
        longint lo;
        longint s;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -(longint'(1) <<< (aw - 1));
        s  = acc + p;
`ifdef APPROX_DOT_ACCUM_SAT_EN
        if (s > hi) begin
            s   = hi;
            sat = 1'b1;
        end else if (s < lo) begin
            s   = lo;
            sat = 1'b1;
        end
`else
        if (s > hi) s = s - (longint'(1) <<< aw);
        else if (s < lo) s = s + (longint'(1) <<< aw);
`endif
        acc = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Phase: 0 idle, 1 accepting products, 2 result presented.
    always @(negedge clk) begin
        chk("busy", longint'(bus.busy), longint'(phase != 0));
        chk("in_ready", longint'(bus.in_ready), longint'(phase == 1));
        chk("out_valid", longint'(bus.out_valid), longint'(phase == 2));
        if (phase == 2) begin
            chk("out_acc", longint'($signed(bus.out_acc)), exp_acc);
            chk("out_sat", longint'(bus.out_sat), longint'(exp_sat));
        end
    end

    task automatic run_vec(input int gap, input int hold, input bit start_in_done,
                           input bit lit_en, input longint lit_acc);
        int n;
        bit b;
        n = vq.size();
        bus.start = 1'b1;
        bus.len   = LW'(n);
        step();
        bus.start = 1'b0;
        bus.len   = LW'($urandom);
        exp_acc   = 0;
        exp_sat   = 1'b0;
        phase     = (n == 0) ? 2 : 1;
        foreach (vq[i]) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.in_p     = PW'($urandom);
                bus.start    = 1'($urandom_range(0, 1));
                step();
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_p     = PW'(vq[i]);
            step();
            model_add(AW, longint'(vq[i]), exp_acc, exp_sat);
            bus.in_valid = 1'b0;
            if (i == n - 1) phase = 2;
        end
        if (lit_en) chk("literal_acc", longint'($signed(bus.out_acc)), lit_acc);
        repeat (hold) begin
            bus.out_ready = 1'b0;
            bus.start     = start_in_done;
            bus.len       = LW'($urandom);
            bus.in_valid  = 1'($urandom_range(0, 1));
            step();
        end
        b = 1'($urandom_range(0, 1));
        bus.out_ready = 1'b1;
        bus.start     = start_in_done | b;
        bus.in_valid  = 1'b0;
        step();
        phase         = 0;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'($urandom_range(0, 1));
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic small_vec(input bit lit_en, input longint la, input bit ls);
        longint a;
        bit     s;
        int     k;
        a = 0;
        s = 1'b0;
        k = 0;
        sbus.start = 1'b1;
        sbus.len   = LW'(sq.size());
        step();
        sbus.start = 1'b0;
        foreach (sq[i]) begin
            chk("small_in_ready", longint'(sbus.in_ready), 1);
            sbus.in_valid = 1'b1;
            sbus.in_p     = PW'(sq[i]);
            step();
            model_add(SAW, longint'(sq[i]), a, s);
        end
        sbus.in_valid = 1'b0;
        while (!sbus.out_valid && k < 10) begin
            step();
            k++;
        end
        chk("small_out_valid", longint'(sbus.out_valid), 1);
        chk("small_acc", longint'($signed(sbus.out_acc)), a);
        chk("small_sat", longint'(sbus.out_sat), longint'(s));
        if (lit_en) begin
            chk("small_literal_acc", longint'($signed(sbus.out_acc)), la);
            chk("small_literal_sat", longint'(sbus.out_sat), longint'(ls));
        end
        sbus.out_ready = 1'b1;
        step();
        sbus.out_ready = 1'b0;
        chk("small_idle", longint'(sbus.busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.in_valid   = 1'b0;
        bus.in_p       = '0;
        bus.out_ready  = 1'b0;
        sbus.start     = 1'b0;
        sbus.len       = '0;
        sbus.in_valid  = 1'b0;
        sbus.in_p      = '0;
        sbus.out_ready = 1'b0;
        step();
        step();
        chk("reset_acc", longint'(bus.out_acc), 0);
        chk("reset_sat", longint'(bus.out_sat), 0);
        rst_n = 1'b1;
        step();

        vq = '{100, -20, 5};
        run_vec(0, 0, 1'b0, 1'b1, 85);

        vq = {};
        run_vec(0, 2, 1'b1, 1'b1, 0);

        vq = '{32767, 32767, 32767, 32767};
        run_vec(2, 5, 1'b1, 1'b1, 131068);

        // Abort a vector with reset after two accepted products.
        bus.start = 1'b1;
        bus.len   = LW'(5);
        step();
        bus.start = 1'b0;
        phase     = 1;
        repeat (2) begin
            bus.in_valid = 1'b1;
            bus.in_p     = PW'(1000);
            step();
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_acc", longint'(bus.out_acc), 0);
        chk("rst_out_sat", longint'(bus.out_sat), 0);
        phase = 0;
        step();
        rst_n = 1'b1;
        repeat (3) begin
            bus.in_valid = 1'b1;
            bus.in_p     = PW'(55);
            step();
        end
        bus.in_valid = 1'b0;
        vq = '{-7};
        run_vec(0, 1, 1'b0, 1'b1, -7);

        repeat (40) begin
            int n;
            n  = $urandom_range(0, 10);
            vq = {};
            repeat (n) vq.push_back(int'($urandom_range(0, 65535)) - 32768);
            run_vec(-1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        vq = {};
        repeat (200) vq.push_back($urandom_range(0, 1) != 0 ? 32767 : 30000);
        run_vec(0, 1, 1'b0, 1'b0, 0);

        sq = '{32767, 1};
`ifdef APPROX_DOT_ACCUM_SAT_EN
        small_vec(1'b1, 32767, 1'b1);
`else
        small_vec(1'b1, -32768, 1'b0);
`endif
        sq = '{-32768, -1};
`ifdef APPROX_DOT_ACCUM_SAT_EN
        small_vec(1'b1, -32768, 1'b1);
`else
        small_vec(1'b1, 32767, 1'b0);
`endif
        repeat (10) begin
            int n;
            n  = $urandom_range(1, 6);
            sq = {};
            repeat (n) begin
                if ($urandom_range(0, 1) != 0)
                    sq.push_back($urandom_range(0, 1) != 0 ? 32767 : -32768);
                else
                    sq.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            small_vec(1'b0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_dot_accum.md
APPROX_DOT_ACCUM -- requirements
Module: approx_dot_accum

Interface
REQ-001 SHALL have parameter PW, default 16, product input width in bits.
REQ-002 SHALL have parameter AW, default 24, accumulator width in bits; AW >= PW.
REQ-003 SHALL have parameter LW, default 8, vector-length field width in bits.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a new dot product.
REQ-007 SHALL have port len  input  LW  number of products to accumulate; sampled with start.
REQ-008 SHALL have port in_valid  input  1  upstream product valid.
REQ-009 SHALL have port in_p  input  PW  signed two's-complement product from the upstream radix-4 Booth approximate multiplier.
REQ-010 SHALL have port in_ready  output  1  block accepts in_p this cycle.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_acc  output  AW  signed accumulated result.
REQ-014 SHALL have port out_sat  output  1  result was clamped at least once.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, ACCUM, DONE.
REQ-017 In IDLE, start=1 SHALL capture len, clear acc, count and sat, and go to ACCUM; if len=0 it SHALL go directly to DONE with out_acc=0.
REQ-018 start SHALL be ignored in ACCUM and DONE.
REQ-019 in_ready SHALL be 1 only in ACCUM; in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 A transfer occurs on in_valid & in_ready; each transfer SHALL add sign-extended in_p to acc and increment count.
REQ-021 The transfer making count equal len SHALL move the FSM to DONE on the same edge; out_valid SHALL be 1 the following cycle, including the final sum.
REQ-022 In ACCUM, cycles with in_valid=0 SHALL leave acc and count unchanged; no timeout.
REQ-023 In DONE, out_valid=1 and out_acc/out_sat SHALL remain stable until out_valid & out_ready, after which the FSM SHALL return to IDLE.
REQ-024 A start on the same cycle as the DONE-to-IDLE handshake SHALL be ignored.
REQ-025 Arithmetic SHALL be signed, AW+1 bits internally before wrap or saturation.
REQ-026 out_acc SHALL equal the internal acc register directly (no combinational path from in_p).

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, acc=0, count=0, sat=0, in_ready=0, out_valid=0, out_acc=0, out_sat=0, busy=0.
REQ-028 Reset asserted mid-vector SHALL discard partial results; no product is accepted until a new start after release.

Configuration
REQ-029 Macro APPROX_DOT_ACCUM_SAT_EN defined: each addition SHALL clamp to +(2^(AW-1)-1) or -2^(AW-1) on overflow and set sticky sat.
REQ-030 Macro undefined: additions SHALL wrap modulo 2^AW and out_sat SHALL be tied to 0.

Structure
REQ-031 A shared package approx_pkg SHALL hold the state enumeration (IDLE, ACCUM, DONE) and default width constants PW, AW, LW.
REQ-032 Sub-module sat_add SHALL implement the signed add with optional clamp and overflow flag; the FSM and counter SHALL be in approx_dot_accum.

Verification
REQ-033 start, len=3; products 100, -20, 5 back-to-back -> out_valid 1 cycle after third transfer, out_acc=85, out_sat=0.
REQ-034 start, len=0 -> out_valid next cycle, out_acc=0, no in_ready pulse.
REQ-035 len=4; in_valid gaps of 2 cycles between products 16'h7FFF x4; out_ready held 0 for 5 cycles -> out_acc=131068 stable throughout; start during DONE ignored.
REQ-036 AW=16, len=2, products 16'h7FFF, 16'h0001 -> with APPROX_DOT_ACCUM_SAT_EN out_acc=32767, out_sat=1; without, out_acc=-32768, out_sat=0.
REQ-037 len=5, rst_n pulsed low after 2 transfers -> all outputs 0 immediately; next start, len=1, product -7 -> out_acc=-7.
